// File: rtl/seq_pkg.sv
// Shared encodings and default sizes for the serial pattern transmitter.
// The state codes double as the LED-visible bit pattern on o_bit2..o_bit0.
package seq_pkg;

  localparam int N_DEF  = 8;
  localparam int LW_DEF = 4;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_LOAD  = 3'b001;
  localparam logic [2:0] ST_SHIFT = 3'b010;
  localparam logic [2:0] ST_DONE  = 3'b011;

endpackage

// File: rtl/dff.sv
// Single-bit D flip-flop with synchronous, active-high reset to a
// parameterised value.
module dff #(
  parameter logic Default = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) r_q <= Default;
    else       r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_pattern_gen.sv
// Latches a 1..N bit pattern on start and shifts it out MSB-first on o_w,
// with optional repeat and abort.
//
// Handshake: there is no back-pressure. o_valid is high exactly in the
// cycles where o_w carries a pattern bit, o_done pulses for one cycle after
// the last bit, and i_start is only honoured while the block is idle.
module serial_pattern_gen
  import seq_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic [N-1:0]  i_pattern,
  input  logic [LW-1:0] i_len,
  input  logic          i_repeat,
  input  logic          i_abort,
  output logic          o_w,
  output logic          o_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_bit0,
  output logic          o_bit1,
  output logic          o_bit2
);

  logic [2:0]    w_state;
  logic [2:0]    w_next_c;
  wire  [2:0]    w_state_d;
  logic          w_accept;
  logic [LW-1:0] w_len_sat;
  logic [LW-1:0] w_shamt;

  logic [N-1:0]  r_pat_q;
  logic [LW-1:0] r_len_q;
  logic [N-1:0]  r_sreg;
  logic [LW-1:0] r_cnt;

  assign w_accept  = i_start && (i_len != '0);
  assign w_len_sat = (i_len > LW'(N)) ? LW'(N) : i_len;
  // Left-align the pattern so bit len_q-1 sits at the shift-out position.
  assign w_shamt   = LW'(N) - r_len_q;

  always_comb begin
    w_next_c = ST_IDLE;
    if (!i_abort) begin
      case (w_state)
        ST_IDLE:  w_next_c = w_accept ? ST_LOAD : ST_IDLE;
        ST_LOAD:  w_next_c = ST_SHIFT;
        ST_SHIFT: w_next_c = (r_cnt == LW'(1)) ? ST_DONE : ST_SHIFT;
        ST_DONE:  w_next_c = i_repeat ? ST_LOAD : ST_IDLE;
        default:  w_next_c = ST_IDLE;
      endcase
    end
  end

  assign w_state_d = w_next_c;

  dff #(.Default(1'b0)) u_bit0 (.clk(clk), .reset(reset), .i_d(w_state_d[0]), .o_q(w_state[0]));
  dff #(.Default(1'b0)) u_bit1 (.clk(clk), .reset(reset), .i_d(w_state_d[1]), .o_q(w_state[1]));
  dff #(.Default(1'b0)) u_bit2 (.clk(clk), .reset(reset), .i_d(w_state_d[2]), .o_q(w_state[2]));

  // Abort leaves the datapath stale; outputs stay quiet because they
  // decode from the state alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat_q <= '0;
      r_len_q <= '0;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else if (!i_abort) begin
      case (w_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pat_q <= i_pattern;
            r_len_q <= w_len_sat;
          end
        end
        ST_LOAD: begin
          r_sreg <= r_pat_q << w_shamt;
          r_cnt  <= r_len_q;
        end
        ST_SHIFT: begin
          r_sreg <= r_sreg << 1;
          r_cnt  <= r_cnt - LW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (w_state == ST_SHIFT);
  assign o_w     = o_valid & r_sreg[N-1];
  assign o_busy  = (w_state != ST_IDLE);
  assign o_done  = (w_state == ST_DONE);
  assign o_bit0  = w_state[0];
  assign o_bit1  = w_state[1];
  assign o_bit2  = w_state[2];

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: directed timing traces plus randomized
// requests checked by a bit-stream scoreboard fed from a reference model.
module tb_serial_pattern_gen;
  import seq_pkg::*;

  localparam int N  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [N-1:0]  i_pattern;
  logic [LW-1:0] i_len;
  logic          i_repeat;
  logic          i_abort;
  logic          o_w, o_valid, o_busy, o_done, o_bit0, o_bit1, o_bit2;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  int         done_q[$];
  int         bits_seen = 0;

  serial_pattern_gen #(.N(N), .LW(LW)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_pattern(i_pattern),
    .i_len(i_len), .i_repeat(i_repeat), .i_abort(i_abort),
    .o_w(o_w), .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done),
    .o_bit0(o_bit0), .o_bit1(o_bit1), .o_bit2(o_bit2)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int sat_len(input logic [LW-1:0] len);
    return (int'(len) > N) ? N : int'(len);
  endfunction

  // Every transmission sends pattern[l-1] down to pattern[0], then one done.
  task automatic push_model(input logic [N-1:0] pat, input int l, input int reps);
    for (int r = 0; r <= reps; r++) begin
      for (int b = l - 1; b >= 0; b--) exp_q.push_back(pat[b]);
      done_q.push_back(l);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (o_valid) begin
        if (exp_q.size() == 0) check_fail("stray_bit");
        else check("w_bit", o_w, exp_q.pop_front());
        bits_seen++;
      end else begin
        check("w_gated", o_w, 0);
      end
      if (o_done) begin
        if (done_q.size() == 0) check_fail("unexpected_done");
        else check("done_len", bits_seen, done_q.pop_front());
        bits_seen = 0;
      end else if (!o_busy) begin
        bits_seen = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy && n < 200);
    if (o_busy) check_fail("idle_timeout");
  endtask

  task automatic check_state(input string name, input logic [2:0] exp_st);
    check({name, "_state"}, {o_bit2, o_bit1, o_bit0}, exp_st);
    check({name, "_valid"}, o_valid, exp_st == ST_SHIFT);
    check({name, "_done"},  o_done,  exp_st == ST_DONE);
    check({name, "_busy"},  o_busy,  exp_st != ST_IDLE);
  endtask

  // Cycle-exact trace: n=1 LOAD, n=2..l+1 bits, n=l+2 DONE, n=l+3 IDLE.
  task automatic trace_send(input logic [N-1:0] pat, input logic [LW-1:0] len);
    int l;
    logic [2:0] exp_st;
    logic exp_w;
    l = sat_len(len);
    wait_idle();
    i_pattern = pat; i_len = len; i_start = 1'b1; i_repeat = 1'b0;
    push_model(pat, l, 0);
    for (int n = 1; n <= l + 3; n++) begin
      @(negedge clk);
      if (n == 1) i_start = 1'b0;
      if (n == 1)           exp_st = ST_LOAD;
      else if (n <= l + 1)  exp_st = ST_SHIFT;
      else if (n == l + 2)  exp_st = ST_DONE;
      else                  exp_st = ST_IDLE;
      exp_w = (n >= 2 && n <= l + 1) ? pat[l - 1 - (n - 2)] : 1'b0;
      check_state("trace", exp_st);
      check("trace_w", o_w, exp_w);
    end
  endtask

  task automatic send(input logic [N-1:0] pat, input logic [LW-1:0] len,
                      input int reps, input bit poke);
    int l, d, cyc, last, budget;
    l = sat_len(len);
    wait_idle();
    i_pattern = pat; i_len = len; i_start = 1'b1; i_repeat = (reps > 0);
    if (l > 0) push_model(pat, l, reps);
    d = 0; last = 0;
    @(negedge clk);
    cyc = 1;
    i_start = 1'b0; i_pattern = N'($urandom); i_len = LW'($urandom);
    if (l == 0) begin
      repeat (3) begin
        check("len0_busy", o_busy, 0);
        @(negedge clk);
      end
      i_repeat = 1'b0;
    end else begin
      budget = (reps + 1) * (l + 2) + 10;
      while (d < reps + 1 && cyc < budget) begin
        if (poke && cyc == 4) begin
          i_start = 1'b1; i_pattern = '1; i_len = LW'(3);
        end else begin
          i_start = 1'b0;
        end
        if (o_done) begin
          d++;
          if (d > 1) check("repeat_period", cyc - last, l + 2);
          last = cyc;
          i_repeat = (d <= reps);
        end
        if (d < reps + 1) begin
          @(negedge clk);
          cyc++;
        end
      end
      if (d < reps + 1) check_fail("done_timeout");
      i_start = 1'b0; i_repeat = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] ap;
    logic [N-1:0] rp;
    reset = 1'b1; i_start = 1'b1; i_len = LW'(3); i_pattern = 8'hFF;
    i_repeat = 1'b0; i_abort = 1'b0;

    // Reset held two cycles with a pending start.
    repeat (2) begin
      @(negedge clk);
      check_state("reset", ST_IDLE);
      check("reset_w", o_w, 0);
    end
    reset = 1'b0; i_start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_state("post_reset", ST_IDLE);
    end

    // Directed timing traces.
    trace_send(8'b0000_0110, LW'(3));
    trace_send(8'hA5, LW'(8));
    trace_send(8'h3C, LW'(9));
    trace_send(8'h01, LW'(1));

    // Zero length is ignored.
    send(8'hFF, LW'(0), 0, 1'b0);

    // Repeat: two-bit pattern sent three times.
    send(8'b10, LW'(2), 2, 1'b0);

    // Abort during the second SHIFT cycle.
    wait_idle();
    ap = 8'hC3;
    i_pattern = ap; i_len = LW'(8); i_start = 1'b1;
    exp_q.push_back(ap[7]);
    exp_q.push_back(ap[6]);
    @(negedge clk); i_start = 1'b0;
    @(negedge clk);
    @(negedge clk); i_abort = 1'b1;
    @(negedge clk); i_abort = 1'b0;
    check_state("abort", ST_IDLE);
    check("abort_w", o_w, 0);
    repeat (3) @(negedge clk);
    send(8'h16, LW'(5), 0, 1'b0);

    // Illegal state code recovers to IDLE.
    wait_idle();
    force dut.w_state_d = 3'b101;
    @(negedge clk);
    release dut.w_state_d;
    check("illegal_state", {o_bit2, o_bit1, o_bit0}, 3'b101);
    check("illegal_valid", o_valid, 0);
    @(negedge clk);
    check_state("illegal_recover", ST_IDLE);

    // Start while busy is ignored.
    send(8'h5A, LW'(8), 0, 1'b1);

    // Randomized requests.
    for (int i = 0; i < 40; i++) begin
      rp = N'($urandom);
      send(rp, LW'($urandom_range(0, 10)),
           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, 1'b0);
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
